// File: rtl/xor_stream_accum_if.sv
// xor_stream_accum_if
// Streaming bundle for the XOR accumulator.
//   Input side : in_valid/in_ready handshake, operands in_a/in_b, mode, clear
//   Output side: out_valid/out_ready handshake, result out_c, out_parity,
//                out_changed, plus the acc_count group-progress indicator
// master = producer/consumer environment, slave = the accumulator itself.
interface xor_stream_accum_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             mode;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_c;
  logic             out_parity;
  logic             out_changed;
  logic [CNT_W-1:0] acc_count;

  modport master (
    output in_valid, in_a, in_b, mode, clear, out_ready,
    input  in_ready, out_valid, out_c, out_parity, out_changed, acc_count
  );

  modport slave (
    input  in_valid, in_a, in_b, mode, clear, out_ready,
    output in_ready, out_valid, out_c, out_parity, out_changed, acc_count
  );
endinterface

// File: rtl/xor_stream_accum.sv
// xor_stream_accum
// Registered XOR stage for streaming checksum/parity. Mode 0 emits a^b per
// beat; mode 1 XOR-folds ACC_LEN beats into a single result.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - xor_stream_accum_if.slave (input/output handshakes, result,
//          parity, changed flag, acc_count)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no partial group; next accepted beat picks the mode
// ACC   | 0 < acc_count < ACC_LEN; group mode latched in mode_q
module xor_stream_accum #(
  parameter int WIDTH   = 8,
  parameter int ACC_LEN = 4,
  parameter int CNT_W   = 3
) (
  input logic          clk,
  input logic          rst,
  xor_stream_accum_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t           state_q;
  logic             mode_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] acc_count_q;
  logic [WIDTH-1:0] out_c_q;
  logic [WIDTH-1:0] prev_c_q;
  logic             out_valid_q;
  logic             out_parity_q;
  logic             out_changed_q;

  logic             out_stall;
  logic             mode_eff;
  logic             final_beat;
  logic             in_ready;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] beat_x;
  logic [WIDTH-1:0] new_c;

  // Mode is only sampled from the port at the start of a group.
  assign mode_eff   = (state_q == S_IDLE) ? bus.mode : mode_q;
  assign out_stall  = out_valid_q && !bus.out_ready;
  assign final_beat = mode_eff && (acc_count_q == LAST);

  // Non-final mode-1 beats only touch acc, so they may proceed under stall.
  assign in_ready = !rst && !bus.clear &&
                    (!out_stall || (mode_eff && (acc_count_q != LAST)));
  assign accept   = bus.in_valid && in_ready;
  assign load     = accept && (!mode_eff || final_beat);
  assign beat_x   = bus.in_a ^ bus.in_b;
  assign new_c    = mode_eff ? (acc_q ^ beat_x) : beat_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_q        <= 1'b0;
      acc_q         <= '0;
      acc_count_q   <= '0;
      out_c_q       <= '0;
      prev_c_q      <= '0;
      out_valid_q   <= 1'b0;
      out_parity_q  <= 1'b0;
      out_changed_q <= 1'b0;
    end else begin
      // A load in the same cycle as a drain keeps out_valid high.
      if (load) begin
        out_valid_q   <= 1'b1;
        out_c_q       <= new_c;
        out_parity_q  <= ^new_c;
        out_changed_q <= (new_c != prev_c_q);
        prev_c_q      <= new_c;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // clear forces in_ready low, so no beat can be accepted alongside it.
      if (bus.clear) begin
        acc_q       <= '0;
        acc_count_q <= '0;
        state_q     <= S_IDLE;
      end else if (accept) begin
        if (state_q == S_IDLE) begin
          mode_q <= bus.mode;
        end
        if (mode_eff) begin
          if (final_beat) begin
            acc_q       <= '0;
            acc_count_q <= '0;
            state_q     <= S_IDLE;
          end else begin
            acc_q       <= acc_q ^ beat_x;
            acc_count_q <= acc_count_q + CNT_W'(1);
            state_q     <= S_ACC;
          end
        end
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_c       = out_c_q;
  assign bus.out_parity  = out_parity_q;
  assign bus.out_changed = out_changed_q;
  assign bus.acc_count   = acc_count_q;

endmodule
